// File: rtl/johnson_phase_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : johnson_phase_decoder_if
//  Purpose  : Bundles the sample inputs and decoded outputs of
//             johnson_phase_decoder. The decoder uses the slave modport and
//             whatever feeds it uses the master modport.
//  Ports    : master -> drives en, jc_in, err_clear; observes decoded outputs
//             slave  -> observes en, jc_in, err_clear; drives decoded outputs
//  Options  : JC_DIR_DETECT_EN adds the 'dir' signal
//  Revision : 1.0  initial release
// ============================================================================
interface johnson_phase_decoder_if #(
    parameter int N     = 4,
    parameter int REV_W = 8,
    parameter int ERR_W = 4
);
    localparam int PH_W = $clog2(2 * N);

    logic               en;
    logic [N-1:0]       jc_in;
    logic               err_clear;
    logic [PH_W-1:0]    phase;
    logic [2*N-1:0]     phase_onehot;
    logic               phase_valid;
    logic               wrap;
    logic [REV_W-1:0]   rev_count;
    logic               seq_err;
    logic               err_sticky;
    logic [ERR_W-1:0]   err_count;
`ifdef JC_DIR_DETECT_EN
    logic               dir;
`endif

    modport master (
`ifdef JC_DIR_DETECT_EN
        input  dir,
`endif
        output en, jc_in, err_clear,
        input  phase, phase_onehot, phase_valid, wrap, rev_count,
        input  seq_err, err_sticky, err_count
    );

    modport slave (
`ifdef JC_DIR_DETECT_EN
        output dir,
`endif
        input  en, jc_in, err_clear,
        output phase, phase_onehot, phase_valid, wrap, rev_count,
        output seq_err, err_sticky, err_count
    );
endinterface
`default_nettype wire

// File: rtl/johnson_phase_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : johnson_phase_decoder
//  Purpose  : Samples an N-bit Johnson counter, checks that each sample is the
//             legal successor of the previous one, and decodes it to a binary
//             phase index and a one-hot phase vector. Counts revolutions and
//             flags/counts sequence errors. All outputs are registered.
//  Ports    : clk    - rising-edge clock
//             reset  - synchronous active-high reset
//             bus    - johnson_phase_decoder_if.slave (en, jc_in, err_clear in;
//                      phase, phase_onehot, phase_valid, wrap, rev_count,
//                      seq_err, err_sticky, err_count [, dir] out)
//  Options  : JC_DIR_DETECT_EN - accept reverse steps in LOCK, add 'dir'
//  Revision : 1.0  initial release
// ============================================================================
module johnson_phase_decoder #(
    parameter int N      = 4,
    parameter int REV_W  = 8,
    parameter int ERR_W  = 4,
    parameter int RELOCK = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    johnson_phase_decoder_if.slave  bus
);
    localparam int              c_PHASES = 2 * N;
    localparam int              c_PH_W   = $clog2(c_PHASES);
    localparam int              c_RC_W   = $clog2(RELOCK + 1);
    localparam logic [c_PH_W-1:0] c_LAST = c_PH_W'(c_PHASES - 1);
    localparam logic [c_RC_W-1:0] c_RELOCK = c_RC_W'(RELOCK);
    localparam logic [c_PHASES-1:0] c_ONE = {{(c_PHASES-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_ACQ  = 2'd0,
        S_LOCK = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    // Codeword for phase k: k ones from the top for k<=N, otherwise
    // (k-N) zeros from the top followed by ones.
    function automatic logic [N-1:0] code_of(input int k);
        logic [N-1:0] c;
        c = '0;
        for (int b = 0; b < N; b++) begin
            if (k <= N) c[b] = (b >= N - k);
            else        c[b] = (b < 2 * N - k);
        end
        return c;
    endfunction

    state_t              r_state,   w_state;
    logic [N-1:0]        r_last,    w_last;
    logic [c_RC_W-1:0]   r_relock,  w_relock;
    logic [c_PH_W-1:0]   r_phase,   w_phase;
    logic [c_PHASES-1:0] r_onehot,  w_onehot;
    logic                r_valid,   w_valid;
    logic                r_wrap,    w_wrap;
    logic [REV_W-1:0]    r_rev,     w_rev;
    logic                r_seq_err, w_seq_err;
    logic                r_sticky,  w_sticky;
    logic [ERR_W-1:0]    r_cnt,     w_cnt;
`ifdef JC_DIR_DETECT_EN
    logic                r_dir,     w_dir;
    logic [N-1:0]        w_pred;
`endif

    logic [c_PHASES-1:0] w_match;
    logic                w_legal;
    logic [c_PH_W-1:0]   w_idx;
    logic [N-1:0]        w_succ;
    logic [c_RC_W-1:0]   w_relock_inc;
    logic                w_raise;

    // One comparator per legal codeword; at most one can match.
    for (genvar k = 0; k < c_PHASES; k++) begin : g_code
        localparam logic [N-1:0] c_CODE = code_of(k);
        assign w_match[k] = (bus.jc_in == c_CODE);
    end

    always_comb begin
        w_legal = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < c_PHASES; k++) begin
            if (w_match[k]) begin
                w_legal = 1'b1;
                w_idx   = c_PH_W'(k);
            end
        end
    end

    assign w_succ       = {~r_last[0], r_last[N-1:1]};
    assign w_relock_inc = r_relock + c_RC_W'(1);
`ifdef JC_DIR_DETECT_EN
    assign w_pred       = {r_last[N-2:0], ~r_last[N-1]};
`endif

    always_comb begin
        w_state   = r_state;
        w_last    = r_last;
        w_relock  = r_relock;
        w_phase   = r_phase;
        w_valid   = r_valid;
        w_wrap    = 1'b0;
        w_rev     = r_rev;
        w_seq_err = 1'b0;
        w_sticky  = r_sticky;
        w_cnt     = r_cnt;
        w_raise   = 1'b0;
`ifdef JC_DIR_DETECT_EN
        w_dir     = r_dir;
`endif

        // Clear first so that a simultaneous error still lands as count 1.
        if (bus.err_clear) begin
            w_sticky = 1'b0;
            w_cnt    = '0;
        end

        if (bus.en) begin
            if (w_legal) w_last = bus.jc_in;

            case (r_state)
                S_ACQ: begin
                    if (w_legal) begin
                        w_state  = S_LOCK;
                        w_phase  = w_idx;
                        w_valid  = 1'b1;
                        w_relock = '0;
                    end else begin
                        w_raise  = 1'b1;
                    end
                end

                S_LOCK: begin
                    if (bus.jc_in == w_succ) begin
                        w_phase = (r_phase == c_LAST) ? '0 : r_phase + c_PH_W'(1);
                        if (r_phase == c_LAST) begin
                            w_wrap = 1'b1;
                            w_rev  = r_rev + REV_W'(1);
                        end
`ifdef JC_DIR_DETECT_EN
                        w_dir = 1'b1;
`endif
                    end else if (bus.jc_in == r_last) begin
                        // Stalled counter: hold everything.
                        w_phase = r_phase;
`ifdef JC_DIR_DETECT_EN
                    end else if (bus.jc_in == w_pred) begin
                        w_phase = (r_phase == '0) ? c_LAST : r_phase - c_PH_W'(1);
                        if (r_phase == '0) begin
                            w_wrap = 1'b1;
                            w_rev  = r_rev - REV_W'(1);
                        end
                        w_dir = 1'b0;
`endif
                    end else begin
                        w_state  = S_ERR;
                        w_valid  = 1'b0;
                        w_relock = '0;
                        w_raise  = 1'b1;
                    end
                end

                S_ERR: begin
                    if (w_legal && (bus.jc_in == w_succ)) begin
                        if (w_relock_inc == c_RELOCK) begin
                            w_state  = S_LOCK;
                            w_phase  = w_idx;
                            w_valid  = 1'b1;
                            w_relock = '0;
                        end else begin
                            w_relock = w_relock_inc;
                        end
                    end else begin
                        w_relock = '0;
                        if (!w_legal) w_raise = 1'b1;
                    end
                end

                default: begin
                    w_state = S_ACQ;
                    w_valid = 1'b0;
                end
            endcase
        end

        if (w_raise) begin
            w_seq_err = 1'b1;
            w_sticky  = 1'b1;
            if (w_cnt != '1) w_cnt = w_cnt + ERR_W'(1);
        end

        w_onehot = w_valid ? (c_ONE << w_phase) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_ACQ;
            r_last    <= '0;
            r_relock  <= '0;
            r_phase   <= '0;
            r_onehot  <= '0;
            r_valid   <= 1'b0;
            r_wrap    <= 1'b0;
            r_rev     <= '0;
            r_seq_err <= 1'b0;
            r_sticky  <= 1'b0;
            r_cnt     <= '0;
`ifdef JC_DIR_DETECT_EN
            r_dir     <= 1'b1;
`endif
        end else begin
            r_state   <= w_state;
            r_last    <= w_last;
            r_relock  <= w_relock;
            r_phase   <= w_phase;
            r_onehot  <= w_onehot;
            r_valid   <= w_valid;
            r_wrap    <= w_wrap;
            r_rev     <= w_rev;
            r_seq_err <= w_seq_err;
            r_sticky  <= w_sticky;
            r_cnt     <= w_cnt;
`ifdef JC_DIR_DETECT_EN
            r_dir     <= w_dir;
`endif
        end
    end

    assign bus.phase        = r_phase;
    assign bus.phase_onehot = r_onehot;
    assign bus.phase_valid  = r_valid;
    assign bus.wrap         = r_wrap;
    assign bus.rev_count    = r_rev;
    assign bus.seq_err      = r_seq_err;
    assign bus.err_sticky   = r_sticky;
    assign bus.err_count    = r_cnt;
`ifdef JC_DIR_DETECT_EN
    assign bus.dir          = r_dir;
`endif
endmodule
`default_nettype wire

// File: tb/tb_johnson_phase_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_johnson_phase_decoder
//  Purpose  : Scoreboard bench for johnson_phase_decoder (N=4). A stimulus
//             process drives directed and random samples and pushes the
//             reference model's expected outputs into a queue; a monitor pops
//             one entry per clock and compares it with the DUT outputs.
//  Options  : JC_DIR_DETECT_EN - model and check reverse stepping and 'dir'
//  Revision : 1.0  initial release
// ============================================================================
module tb_johnson_phase_decoder;
    localparam int N      = 4;
    localparam int REV_W  = 8;
    localparam int ERR_W  = 4;
    localparam int RELOCK = 2;
    localparam int P      = 2 * N;
    localparam int REV_M  = 1 << REV_W;
    localparam int ERR_MX = (1 << ERR_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    johnson_phase_decoder_if #(.N(N), .REV_W(REV_W), .ERR_W(ERR_W)) bus ();

    johnson_phase_decoder #(.N(N), .REV_W(REV_W), .ERR_W(ERR_W), .RELOCK(RELOCK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int phase;
        bit valid;
        bit wrap;
        int rev;
        bit seq_err;
        bit sticky;
        int cnt;
        bit dir;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Legal codeword list, generated by repeatedly applying the successor rule.
    logic [N-1:0] codes [P];

    // Reference model: 0=acquiring, 1=locked, 2=error
    int m_mode, m_phase, m_last, m_relock, m_rev, m_cnt;
    bit m_valid, m_sticky, m_dir;

    function automatic int idx_of(input logic [N-1:0] v);
        for (int k = 0; k < P; k++) if (codes[k] == v) return k;
        return -1;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_last = 0; m_relock = 0; m_rev = 0; m_cnt = 0;
        m_valid = 0; m_sticky = 0; m_dir = 1;
    endtask

    task automatic step(input bit e, input logic [N-1:0] v, input bit clr, input bit rst);
        exp_t x;
        bit   raise;
        int   i;
        @(negedge clk);
        bus.en = e; bus.jc_in = v; bus.err_clear = clr; reset = rst;
        x.wrap = 0; x.seq_err = 0; raise = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (clr) begin m_sticky = 0; m_cnt = 0; end
            if (e) begin
                i = idx_of(v);
                if (m_mode == 0) begin
                    if (i >= 0) begin m_mode = 1; m_phase = i; m_valid = 1; end
                    else raise = 1;
                end else if (m_mode == 1) begin
                    if (i >= 0 && i == (m_last + 1) % P) begin
                        m_phase = i; m_dir = 1;
                        if (i == 0) begin x.wrap = 1; m_rev = (m_rev + 1) % REV_M; end
                    end else if (i >= 0 && i == m_last) begin
                        // stall
`ifdef JC_DIR_DETECT_EN
                    end else if (i >= 0 && i == (m_last + P - 1) % P) begin
                        m_phase = i; m_dir = 0;
                        if (i == P - 1) begin x.wrap = 1; m_rev = (m_rev + REV_M - 1) % REV_M; end
`endif
                    end else begin
                        m_mode = 2; m_valid = 0; m_relock = 0; raise = 1;
                    end
                end else begin
                    if (i >= 0 && i == (m_last + 1) % P) begin
                        m_relock++;
                        if (m_relock == RELOCK) begin
                            m_mode = 1; m_phase = i; m_valid = 1; m_relock = 0;
                        end
                    end else begin
                        m_relock = 0;
                        if (i < 0) raise = 1;
                    end
                end
                if (i >= 0) m_last = i;
            end
            if (raise) begin
                x.seq_err = 1; m_sticky = 1;
                if (m_cnt < ERR_MX) m_cnt++;
            end
        end
        x.phase = m_phase; x.valid = m_valid; x.rev = m_rev;
        x.sticky = m_sticky; x.cnt = m_cnt; x.dir = m_dir;
        q.push_back(x);
    endtask

    function automatic logic [N-1:0] rand_illegal();
        logic [N-1:0] v;
        do v = N'($urandom); while (idx_of(v) >= 0);
        return v;
    endfunction

    // Monitor: one expected entry per clock edge that the stimulus drove.
    initial begin
        exp_t e;
        logic [31:0] oh;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e  = q.pop_front();
                oh = e.valid ? (32'd1 << e.phase) : 32'd0;
                check("phase",        32'(bus.phase),        32'(e.phase));
                check("phase_onehot", 32'(bus.phase_onehot), oh);
                check("phase_valid",  32'(bus.phase_valid),  32'(e.valid));
                check("wrap",         32'(bus.wrap),         32'(e.wrap));
                check("rev_count",    32'(bus.rev_count),    32'(e.rev));
                check("seq_err",      32'(bus.seq_err),      32'(e.seq_err));
                check("err_sticky",   32'(bus.err_sticky),   32'(e.sticky));
                check("err_count",    32'(bus.err_count),    32'(e.cnt));
`ifdef JC_DIR_DETECT_EN
                check("dir",          32'(bus.dir),          32'(e.dir));
`endif
            end
        end
    end

    initial begin
        logic [N-1:0] c;
        int r;
        c = '0;
        for (int k = 0; k < P; k++) begin
            codes[k] = c;
            c = {~c[0], c[N-1:1]};
        end
        reset = 1'b1; bus.en = 1'b0; bus.jc_in = '0; bus.err_clear = 1'b0;
        model_reset();

        // Reset, then one full revolution and back to phase 0
        step(0, '0, 0, 1);
        for (int k = 0; k <= P; k++) step(1, codes[k % P], 0, 0);

        // Walk to phase 3, idle with en=0 (jc_in junk), stall, advance
        for (int k = 1; k <= 3; k++) step(1, codes[k], 0, 0);
        for (int k = 0; k < 5; k++) step(0, N'($urandom), 0, 0);
        step(1, codes[3], 0, 0);
        step(1, codes[4], 0, 0);

        // Skip error at 1100 -> 1111, then relock after two successors
        step(0, '0, 0, 1);
        for (int k = 0; k <= 2; k++) step(1, codes[k], 0, 0);
        step(1, codes[4], 0, 0);
        step(1, codes[5], 0, 0);
        step(1, codes[6], 0, 0);

        // Illegal in ACQ, lock, clear+error together, then saturate
        step(0, '0, 0, 1);
        step(1, 4'b1010, 0, 0);
        step(1, 4'b0000, 0, 0);
        step(1, 4'b1010, 1, 0);
        for (int k = 0; k < 16; k++) step(1, rand_illegal(), 0, 0);

        // Reset mid-revolution, then relock at phase 6 with no error
        step(0, '0, 0, 1);
        for (int k = 0; k <= 5; k++) step(1, codes[k], 0, 0);
        step(0, '0, 0, 1);
        step(1, codes[6], 0, 0);

`ifdef JC_DIR_DETECT_EN
        // Reverse through phase 0 -> 7
        step(0, '0, 0, 1);
        step(1, codes[1], 0, 0);
        step(1, codes[0], 0, 0);
        step(1, codes[7], 0, 0);
`endif

        // Randomized traffic biased toward legal forward motion
        step(0, '0, 0, 1);
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                step(0, '0, 0, 1);
            end else if (r < 12) begin
                step(0, N'($urandom), 0, 0);
            end else begin
                r = $urandom_range(0, 99);
                if      (r < 55) c = codes[(m_last + 1) % P];
                else if (r < 68) c = codes[m_last];
                else if (r < 78) c = codes[(m_last + P - 1) % P];
                else if (r < 90) c = codes[$urandom_range(0, P - 1)];
                else             c = rand_illegal();
                step(1, c, ($urandom_range(0, 19) == 0), 0);
            end
        end

        step(0, '0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Downstream consumer of the team's N-bit Johnson counter; samples the counter's q bus on the same clk.
- Validates that each new sample is the legal successor of the previous one and decodes it to a binary phase index and a one-hot phase vector.
- Counts full revolutions and flags or counts sequence errors.
- Feeds phase-sequenced control logic: multiphase strobes, stepper drive.

Parameters:
N, 4, Johnson counter width; 2N legal codewords; N >= 2
REV_W, 8, revolution counter width
ERR_W, 4, error counter width (saturating)
RELOCK, 2, consecutive legal successor transitions required in ERR before returning to LOCK; >= 1

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high; all state cleared on the clk edge where reset=1
en  input  1  sample qualifier; jc_in ignored when 0
jc_in  input  N  Johnson code from counter q
err_clear  input  1  clears err_sticky and err_count
phase  output  PH_W=$clog2(2N)  decoded phase index 0..2N-1
phase_onehot  output  2N  bit[phase] set when phase_valid, else all zero
phase_valid  output  1  high only in LOCK
wrap  output  1  1-cycle pulse on phase 2N-1 -> 0
rev_count  output  REV_W  revolutions, wraps modulo 2^REV_W
seq_err  output  1  1-cycle pulse per detected error
err_sticky  output  1  set on any error, held until err_clear or reset
err_count  output  ERR_W  errors, saturates at all-ones

Behaviour:
- Codeword map, sequence bit N-1..0:
  - Phase k, 0<=k<=N: top k bits 1, rest 0.
  - Phase k, N<k<2N: top k-N bits 0, rest 1.
  - N=4: 0000=0, 1000=1, 1100=2, 1110=3, 1111=4, 0111=5, 0011=6, 0001=7.
  - Any other pattern is illegal.
- Successor of code c is {~c[0], c[N-1:1]}.
- All outputs are registered. A sample taken with en=1 at edge t is reflected in the outputs after edge t; latency is 1 cycle. en=0: all state and outputs hold; wrap and seq_err are 0.
- Reset values: state ACQ, phase 0, phase_onehot 0, phase_valid 0, wrap 0, rev_count 0, seq_err 0, err_sticky 0, err_count 0, internal last-code register 0, relock counter 0.
- FSM: ACQ, LOCK, ERR. Evaluated only on en=1.
  - ACQ:
    - Legal codeword -> LOCK; phase loads the decoded index; phase_valid=1.
    - Illegal codeword -> stay ACQ; error raised.
  - LOCK:
    - Sample equals successor of last code -> phase advances by 1 modulo 2N.
    - Sample equals last code -> hold. Stall is legal; no error.
    - Anything else -> ERR; error raised; phase_valid=0; phase holds its last value.
  - ERR:
    - Legal successor of last code -> relock counter +1.
    - Legal codeword that is not the successor -> relock counter reset to 0; no new error.
    - Illegal codeword -> relock counter 0; error raised.
    - Relock counter reaching RELOCK -> LOCK; phase = decoded sample; phase_valid=1 on that same output cycle.
- The last-code register updates on every en=1 sample that is a legal codeword.
- Error raised means: seq_err=1 for 1 cycle, err_sticky<=1, err_count +1 (saturating).
- wrap: asserted when LOCK advances from phase 2N-1 to 0; rev_count +1 on the same edge. Not asserted on entry into LOCK, even at phase 0.
- err_clear and an error on the same edge: clear applies first, then the error. Result: err_count=1, err_sticky=1.
- reset has priority over en and err_clear. reset mid-revolution returns to ACQ; the next legal sample relocks with no error.

Optional Feature:
- Macro JC_DIR_DETECT_EN.
- Defined:
  - LOCK also accepts the predecessor {c[N-2:0], ~c[N-1]} as legal; phase decrements modulo 2N.
  - Extra output dir, 1 bit: 1 = forward, 0 = reverse; reset value 1.
  - wrap also fires on reverse 0 -> 2N-1; rev_count decrements on reverse wrap.
- Undefined: a predecessor sample is a sequence error; no dir port exists.

Test Plan:
- N=4. Reset, then 0000,1000,...,0001,0000 with en=1 every cycle -> phase 0..7,0; phase_valid=1 from the first sample; wrap=1 exactly once; rev_count=1; err_count=0.
- Locked at phase 3 (1110), hold en=0 for 5 cycles, then 1110 again, then 1111 -> phase stays 3, then 4; no seq_err.
- Locked at 1100, inject 1111 (skip) -> seq_err pulse, phase_valid=0, err_count=1. Then 0111, 0011 -> relock after the second transition, phase=6.
- Inject illegal 1010 in ACQ -> seq_err=1, state ACQ. Then 0000 -> LOCK, phase 0, err_sticky=1. Assert err_clear together with a new error -> err_count=1. 16 further errors -> err_count saturates at 15.
- Reset asserted at phase 5 -> next cycle: all outputs zero, phase_valid=0. Then 0011 -> phase 6, phase_valid=1, no error.
- JC_DIR_DETECT_EN defined: 1000 then 0000 then 0001 -> phase 1, 0, 7; dir=0; wrap=1; rev_count decrements 0 -> 255.
